mips_io_responder: RTL

MIPS_IO_RESPONDER -- requirements
Module: mips_io_responder

---
 rtl/mips_io_pkg.sv | 21 ++
 rtl/mips_io_responder_uart_tx_engine.sv | 88 ++++++++
 rtl/mips_io_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_io_pkg.sv
// mips_io_pkg: register offsets, STATUS bit positions and UART FSM states
// shared by the MIPS memory-mapped I/O responder and its UART engine.
package mips_io_pkg;

  localparam logic [3:0] OFF_PORT_OUT = 4'h0;
  localparam logic [3:0] OFF_PORT_IN  = 4'h4;
  localparam logic [3:0] OFF_TX_DATA  = 4'h8;
  localparam logic [3:0] OFF_STATUS   = 4'hC;

  localparam int ST_BUSY    = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_IN_CHG  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/mips_io_responder_uart_tx_engine.sv
// uart_tx_engine: 8N1 transmitter, one start bit, 8 data bits LSB first,
// one stop bit, each lasting CLKS_PER_BIT clocks. Line idles high.
module uart_tx_engine
  import mips_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);
  assign busy_o  = (state_q != S_IDLE);

  // Next-state: bit-period counter, bit index and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          sh_d    = data_i;
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from state so reset forces it high at once
  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = sh_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: rtl/mips_io_responder.sv
// mips_io_responder: 16-byte MMIO window with output port, synced input
// port, UART TX and status. UART built only with MIPS_IO_UART_EN defined.
module mips_io_responder
  import mips_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        IoSelect,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        TxSerial
);

  logic        hit;
  logic [3:0]  off;
  logic        wr_out, wr_tx, wr_st;
  logic [31:0] port_out_q;
  logic [7:0]  sync1_q, sync2_q;
  logic        in_chg_q, in_chg_d;
  logic        busy, overrun;
  logic [31:0] status;
  logic        unused_addr;

  assign unused_addr = ^Address[1:0];
  assign hit      = (Address[31:4] == BASE_ADDRESS[31:4]);
  assign IoSelect = hit;
  assign off      = {Address[3:2], 2'b00};
  assign wr_out   = hit && MemWrite && (off == OFF_PORT_OUT);
  assign wr_tx    = hit && MemWrite && (off == OFF_TX_DATA);
  assign wr_st    = hit && MemWrite && (off == OFF_STATUS);
  assign PortOut  = port_out_q;

  always_comb begin
    status             = '0;
    status[ST_BUSY]    = busy;
    status[ST_OVERRUN] = overrun;
    status[ST_IN_CHG]  = in_chg_q;
  end

`ifdef MIPS_IO_UART_EN
  logic ovr_q, ovr_d;

  uart_tx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .start_i(wr_tx && !busy),
    .data_i (WriteData[7:0]),
    .busy_o (busy),
    .tx_o   (TxSerial)
  );

  // Overrun: dropped store sets it, W1C clears, set wins
  always_comb begin
    ovr_d = ovr_q;
    if (wr_st && WriteData[ST_OVERRUN]) ovr_d = 1'b0;
    if (wr_tx && busy) ovr_d = 1'b1;
  end

  // Overrun flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`else
  logic unused_tx;
  assign unused_tx = wr_tx;
  assign busy      = 1'b0;
  assign overrun   = 1'b0;
  assign TxSerial  = 1'b1;
`endif

  // Synced value changes at the edge where sync2 takes sync1; set wins
  always_comb begin
    in_chg_d = in_chg_q;
    if (wr_st && WriteData[ST_IN_CHG]) in_chg_d = 1'b0;
    if (sync1_q != sync2_q) in_chg_d = 1'b1;
  end

  // Output port, input synchronizer and change flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      in_chg_q   <= 1'b0;
    end else begin
      if (wr_out) port_out_q <= WriteData;
      sync1_q  <= PortIn;
      sync2_q  <= sync1_q;
      in_chg_q <= in_chg_d;
    end
  end

  // Zero-latency load mux; returns pre-write values
  always_comb begin
    ReadData = '0;
    if (hit && MemRead) begin
      unique case (off)
        OFF_PORT_OUT: ReadData = port_out_q;
        OFF_PORT_IN:  ReadData = {24'h0, sync2_q};
        OFF_STATUS:   ReadData = status;
        default:      ReadData = '0;
      endcase
    end
  end

endmodule
